// File: rtl/mc_controller_v2.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and write-back
// steps, with memory wait-states, byte/half sizing, an illegal-opcode trap and a state port.
module mc_controller_v2 #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_HALF  = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic [1:0] MemToReg,
    output logic       MemWrite,
    output logic [1:0] npc_sel,
    output logic [1:0] ALUOp,
    output logic [1:0] ExtOp,
    output logic       write_30,
    output logic       pcwr,
    output logic       irwr,
    output logic [1:0] mem_size,
    output logic       mem_sext,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB       = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_JR     = 6'b001000;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam state_e ILLEGAL_NEXT = TRAP_ILLEGAL ? S_TRAP : S_FETCH;

    state_e     state_q;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic       rdy;
    logic [1:0] acc_size;
    logic       acc_sext;

    // An access completes in the cycle mem_rdy is sampled high; the IR/PC load and the
    // store strobe are qualified by it so each access produces exactly one strobe.
    assign rdy   = MEM_HANDSHAKE ? mem_rdy : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (rdy) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q    <= opcode;
                    funct_q <= funct;
                    case (opcode)
                        OP_RTYPE:                   state_q <= (funct == F_JR) ? S_JUMP : S_EXEC_R;
                        OP_ORI, OP_LUI, OP_ADDIU:   state_q <= S_EXEC_I;
                        OP_LW, OP_LB, OP_SW, OP_SB: state_q <= S_MEM_ADDR;
                        OP_LH, OP_SH:               state_q <= SUPPORT_HALF ? S_MEM_ADDR : ILLEGAL_NEXT;
                        OP_BEQ:                     state_q <= S_BRANCH;
                        OP_J, OP_JAL:               state_q <= S_JUMP;
                        default:                    state_q <= ILLEGAL_NEXT;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_q <= S_WB;
                // Stores are the 101xxx opcodes, loads 100xxx.
                S_MEM_ADDR: state_q <= op_q[3] ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (rdy) state_q <= S_MEM_WB;
                S_MEM_WR:   if (rdy) state_q <= S_FETCH;
                S_TRAP:     state_q <= S_TRAP;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        acc_size = SIZE_WORD;
        if (op_q[1:0] == 2'b00) begin
            acc_size = SIZE_BYTE;
        end else if (op_q[1:0] == 2'b01) begin
            acc_size = SIZE_HALF;
        end
        acc_sext = !op_q[3] && (acc_size != SIZE_WORD);
    end

    always_comb begin
        RegDst   = 2'b00;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 2'b00;
        MemWrite = 1'b0;
        npc_sel  = 2'b00;
        ALUOp    = 2'b00;
        ExtOp    = 2'b00;
        write_30 = 1'b0;
        pcwr     = 1'b0;
        irwr     = 1'b0;
        mem_size = 2'b00;
        mem_sext = 1'b0;
        trap     = 1'b0;
        // Reset silences every strobe at once, including the mem_rdy-driven ones.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    irwr = rdy;
                    pcwr = rdy;
                end
                S_EXEC_R: ALUOp = 2'b11;
                S_EXEC_I: begin
                    ALUSrc = 1'b1;
                    if (op_q == OP_ORI) begin
                        ALUOp = 2'b10;
                        ExtOp = 2'b00;
                    end else if (op_q == OP_LUI) begin
                        ALUOp = 2'b10;
                        ExtOp = 2'b10;
                    end else begin
                        ALUOp = 2'b00;
                        ExtOp = 2'b01;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (op_q == OP_RTYPE) ? 2'b01 : 2'b00;
                end
                S_MEM_ADDR: begin
                    ALUSrc   = 1'b1;
                    ExtOp    = 2'b01;
                    mem_size = acc_size;
                    mem_sext = acc_sext;
                end
                S_MEM_RD: begin
                    mem_size = acc_size;
                    mem_sext = acc_sext;
                end
                S_MEM_WB: begin
                    MemToReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = rdy;
                    mem_size = acc_size;
                    mem_sext = acc_sext;
                end
                S_BRANCH: begin
                    ALUOp   = 2'b01;
                    npc_sel = 2'b01;
                    pcwr    = zero;
                end
                S_JUMP: begin
                    pcwr    = 1'b1;
                    npc_sel = (op_q == OP_RTYPE && funct_q == F_JR) ? 2'b11 : 2'b10;
                    if (op_q == OP_JAL) begin
                        write_30 = 1'b1;
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemToReg = 2'b10;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller_v2.sv
// Bench for mc_controller_v2: default build plus a build with handshake, half accesses
// and the trap all disabled, checked cycle by cycle against an instruction-plan model.
module tb_mc_controller_v2;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WB = 4'd6, ST_MEM_WR = 4'd7;
    localparam logic [3:0] ST_WB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_TRAP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111, F_JR = 6'b001000, F_ADDU = 6'b100001;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic [1:0] npc_sel;
        logic [1:0] alu_op;
        logic [1:0] ext_op;
        logic       write_30;
        logic       pcwr;
        logic       irwr;
        logic [1:0] mem_size;
        logic       mem_sext;
        logic       trap;
        logic [3:0] state;
    } out_t;

    typedef struct {
        int         dut;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         fst;
        int         mst;
        int         lat;
        int         rw;
        int         mw;
        int         pcw;
        string      name;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [5:0] opcode, funct;
    logic       zero, mem_rdy;

    logic [1:0] regdst0, memtoreg0, npcsel0, aluop0, extop0, memsize0;
    logic       regwrite0, alusrc0, memwrite0, write30_0, pcwr0, irwr0, memsext0, trap0;
    logic [3:0] state0;
    logic [1:0] regdst1, memtoreg1, npcsel1, aluop1, extop1, memsize1;
    logic       regwrite1, alusrc1, memwrite1, write30_1, pcwr1, irwr1, memsext1, trap1;
    logic [3:0] state1;

    mc_controller_v2 dut (
        .clk(clk), .rst(rst0), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .RegDst(regdst0), .RegWrite(regwrite0), .ALUSrc(alusrc0), .MemToReg(memtoreg0),
        .MemWrite(memwrite0), .npc_sel(npcsel0), .ALUOp(aluop0), .ExtOp(extop0),
        .write_30(write30_0), .pcwr(pcwr0), .irwr(irwr0), .mem_size(memsize0),
        .mem_sext(memsext0), .trap(trap0), .state(state0)
    );

    mc_controller_v2 #(.MEM_HANDSHAKE(1'b0), .SUPPORT_HALF(1'b0), .TRAP_ILLEGAL(1'b0)) dut_lite (
        .clk(clk), .rst(rst1), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .RegDst(regdst1), .RegWrite(regwrite1), .ALUSrc(alusrc1), .MemToReg(memtoreg1),
        .MemWrite(memwrite1), .npc_sel(npcsel1), .ALUOp(aluop1), .ExtOp(extop1),
        .write_30(write30_1), .pcwr(pcwr1), .irwr(irwr1), .mem_size(memsize1),
        .mem_sext(memsext1), .trap(trap1), .state(state1)
    );

    out_t act0, act1, act, last;
    int   cur = 0;

    assign act0 = {regdst0, regwrite0, alusrc0, memtoreg0, memwrite0, npcsel0, aluop0, extop0,
                   write30_0, pcwr0, irwr0, memsize0, memsext0, trap0, state0};
    assign act1 = {regdst1, regwrite1, alusrc1, memtoreg1, memwrite1, npcsel1, aluop1, extop1,
                   write30_1, pcwr1, irwr1, memsize1, memsext1, trap1, state1};
    assign act  = (cur == 1) ? act1 : act0;

    // ---------------- scoreboard counters ----------------
    int npass = 0;
    int nchecks = 0;
    int cyc = 0;

    task automatic check_out(input string name, input out_t got, input out_t want);
        nchecks++;
        if (got === want) npass++;
        else $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", name, cur, cyc, got, want);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        nchecks++;
        if (got == want) npass++;
        else $display("FAIL %s dut=%0d got=%0d want=%0d", name, cur, got, want);
    endtask

    // ---------------- reference model: per-instruction plan of steps ----------------
    logic [3:0] plan_q[$];
    logic [5:0] m_op, m_funct;
    logic [5:0] cur_op, cur_funct;
    bit         cfg_hs, cfg_half, cfg_trap;

    function automatic logic [1:0] size_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_SB) return 2'b10;
        if (op == OP_LH || op == OP_SH) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t exp_outputs(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] fn, input logic rdy, input logic z);
        out_t o;
        logic r;
        o = '0;
        r = cfg_hs ? rdy : 1'b1;
        o.state = st;
        case (st)
            ST_FETCH: begin o.irwr = r; o.pcwr = r; end
            ST_EXEC_R: o.alu_op = 2'b11;
            ST_EXEC_I: begin
                o.alu_src = 1'b1;
                if (op == OP_ORI)      begin o.alu_op = 2'b10; o.ext_op = 2'b00; end
                else if (op == OP_LUI) begin o.alu_op = 2'b10; o.ext_op = 2'b10; end
                else                   begin o.alu_op = 2'b00; o.ext_op = 2'b01; end
            end
            ST_WB: begin o.reg_write = 1'b1; o.reg_dst = (op == OP_R) ? 2'b01 : 2'b00; end
            ST_MEM_ADDR: begin
                o.alu_src = 1'b1; o.ext_op = 2'b01;
                o.mem_size = size_of(op); o.mem_sext = (op == OP_LB || op == OP_LH);
            end
            ST_MEM_RD: begin o.mem_size = size_of(op); o.mem_sext = (op == OP_LB || op == OP_LH); end
            ST_MEM_WB: begin o.mem_to_reg = 2'b01; o.reg_write = 1'b1; end
            ST_MEM_WR: begin o.mem_write = r; o.mem_size = size_of(op); end
            ST_BRANCH: begin o.alu_op = 2'b01; o.npc_sel = 2'b01; o.pcwr = z; end
            ST_JUMP: begin
                o.pcwr = 1'b1;
                o.npc_sel = (op == OP_R && fn == F_JR) ? 2'b11 : 2'b10;
                if (op == OP_JAL) begin
                    o.write_30 = 1'b1; o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
                end
            end
            ST_TRAP: o.trap = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic build_plan(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_R) begin
            if (fn == F_JR) plan_q.push_back(ST_JUMP);
            else begin plan_q.push_back(ST_EXEC_R); plan_q.push_back(ST_WB); end
        end else if (op inside {OP_ORI, OP_LUI, OP_ADDIU}) begin
            plan_q.push_back(ST_EXEC_I); plan_q.push_back(ST_WB);
        end else if (op inside {OP_LW, OP_LB} || (cfg_half && op == OP_LH)) begin
            plan_q.push_back(ST_MEM_ADDR); plan_q.push_back(ST_MEM_RD); plan_q.push_back(ST_MEM_WB);
        end else if (op inside {OP_SW, OP_SB} || (cfg_half && op == OP_SH)) begin
            plan_q.push_back(ST_MEM_ADDR); plan_q.push_back(ST_MEM_WR);
        end else if (op == OP_BEQ || op == OP_J || op == OP_JAL) begin
            plan_q.push_back((op == OP_BEQ) ? ST_BRANCH : ST_JUMP);
        end else if (cfg_trap) begin
            plan_q.push_back(ST_TRAP);
        end
    endtask

    task automatic advance();
        logic [3:0] s;
        s = plan_q[0];
        if (s == ST_TRAP) return;
        if (cfg_hs && !mem_rdy && (s == ST_FETCH || s == ST_MEM_RD || s == ST_MEM_WR)) return;
        void'(plan_q.pop_front());
        if (s == ST_FETCH) plan_q.push_back(ST_DECODE);
        else if (s == ST_DECODE) begin
            m_op = opcode; m_funct = funct;
            build_plan(opcode, funct);
        end
        if (plan_q.size() == 0) plan_q.push_back(ST_FETCH);
    endtask

    task automatic model_reset(input int which);
        plan_q.delete();
        plan_q.push_back(ST_FETCH);
        m_op = '0; m_funct = '0;
        cfg_hs = (which == 0); cfg_half = (which == 0); cfg_trap = (which == 0);
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [3:0] cur_state();
        return (cur == 1) ? state1 : state0;
    endfunction

    task automatic cycle(input logic rdy, input logic z);
        logic rst_now;
        opcode  = (plan_q[0] == ST_DECODE) ? cur_op : 6'($urandom);
        funct   = (plan_q[0] == ST_DECODE) ? cur_funct : 6'($urandom);
        mem_rdy = rdy;
        zero    = z;
        @(negedge clk);
        rst_now = (cur == 1) ? rst1 : rst0;
        check_out("cycle", act, rst_now ? out_t'('0) : exp_outputs(plan_q[0], m_op, m_funct, rdy, z));
        last = act;
        if (!rst_now) advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int which);
        cur = which;
        rst0 = 1'b1; rst1 = 1'b1;
        mem_rdy = 1'b1; zero = 1'b1; opcode = 6'($urandom); funct = 6'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out("reset_dut0", act0, '0);
        check_out("reset_dut1", act1, '0);
        model_reset(which);
        @(posedge clk);
        #1;
        if (which == 0) rst0 = 1'b0;
        else rst1 = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fst, input int mst, input bit rnd,
                             output int lat, output int rw, output int mw, output int pcw);
        bit   seen;
        logic r;
        int   fs, ms;
        cur_op = op; cur_funct = fn; fs = fst; ms = mst; seen = 0;
        lat = 0; rw = 0; mw = 0; pcw = 0;
        for (int n = 0; n < 60; n++) begin
            if (rnd) r = ($urandom_range(0, 3) != 0);
            else if (plan_q[0] == ST_FETCH && fs > 0) begin r = 1'b0; fs--; end
            else if ((plan_q[0] == ST_MEM_RD || plan_q[0] == ST_MEM_WR) && ms > 0) begin r = 1'b0; ms--; end
            else r = 1'b1;
            cycle(r, z);
            lat++;
            rw += int'(last.reg_write);
            mw += int'(last.mem_write);
            if (last.state != ST_FETCH) pcw += int'(last.pcwr);
            if (last.state == ST_DECODE) seen = 1;
            if (last.state == ST_TRAP) return;
            if (seen && cur_state() == ST_FETCH) return;
        end
        nchecks++;
        $display("FAIL instr_timeout dut=%0d op=%b got=no_fetch want=fetch_within_60", cur, op);
    endtask

    // ---------------- test ----------------
    vec_t       vecs[$];
    logic [5:0] pool[14];
    int         lat, rw, mw, pcw, trapc;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
        cur_op = '0; cur_funct = '0;
        model_reset(0);

        //                dut op        fn      z     fst mst lat rw mw pcw name
        vecs.push_back('{0, OP_R,     F_ADDU, 1'b0, 0, 0, 4, 1, 0, 0, "addu"});
        vecs.push_back('{0, OP_ORI,   6'd0,   1'b0, 0, 0, 4, 1, 0, 0, "ori"});
        vecs.push_back('{0, OP_LUI,   6'd0,   1'b0, 0, 0, 4, 1, 0, 0, "lui"});
        vecs.push_back('{0, OP_ADDIU, 6'd0,   1'b0, 0, 0, 4, 1, 0, 0, "addiu"});
        vecs.push_back('{0, OP_LW,    6'd0,   1'b0, 0, 0, 5, 1, 0, 0, "lw"});
        vecs.push_back('{0, OP_LB,    6'd0,   1'b0, 0, 2, 7, 1, 0, 0, "lb_wait2"});
        vecs.push_back('{0, OP_LH,    6'd0,   1'b0, 1, 0, 6, 1, 0, 0, "lh_fwait1"});
        vecs.push_back('{0, OP_SW,    6'd0,   1'b0, 0, 1, 5, 0, 1, 0, "sw_wait1"});
        vecs.push_back('{0, OP_SB,    6'd0,   1'b0, 0, 0, 4, 0, 1, 0, "sb"});
        vecs.push_back('{0, OP_SH,    6'd0,   1'b0, 2, 1, 7, 0, 1, 0, "sh_wait3"});
        vecs.push_back('{0, OP_BEQ,   6'd0,   1'b1, 0, 0, 3, 0, 0, 1, "beq_taken"});
        vecs.push_back('{0, OP_BEQ,   6'd0,   1'b0, 0, 0, 3, 0, 0, 0, "beq_not"});
        vecs.push_back('{0, OP_J,     6'd0,   1'b0, 0, 0, 3, 0, 0, 1, "j"});
        vecs.push_back('{0, OP_JAL,   6'd0,   1'b0, 0, 0, 3, 1, 0, 1, "jal"});
        vecs.push_back('{0, OP_R,     F_JR,   1'b0, 0, 0, 3, 0, 0, 1, "jr"});
        vecs.push_back('{1, OP_BAD,   6'd0,   1'b0, 0, 0, 2, 0, 0, 0, "lite_illegal"});
        vecs.push_back('{1, OP_LH,    6'd0,   1'b0, 0, 0, 2, 0, 0, 0, "lite_lh_illegal"});
        vecs.push_back('{1, OP_LW,    6'd0,   1'b0, 2, 3, 5, 1, 0, 0, "lite_lw_nowait"});
        vecs.push_back('{1, OP_SW,    6'd0,   1'b0, 0, 2, 4, 0, 1, 0, "lite_sw_nowait"});
        vecs.push_back('{1, OP_BEQ,   6'd0,   1'b1, 0, 0, 3, 0, 0, 1, "lite_beq"});

        do_reset(0);
        foreach (vecs[i]) begin
            if (vecs[i].dut != cur) do_reset(vecs[i].dut);
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].fst, vecs[i].mst, 1'b0, lat, rw, mw, pcw);
            check_int({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check_int({vecs[i].name, "_regwrite"}, rw, vecs[i].rw);
            check_int({vecs[i].name, "_memwrite"}, mw, vecs[i].mw);
            check_int({vecs[i].name, "_pcwr"}, pcw, vecs[i].pcw);
        end

        // Reset in the middle of a store: the write strobe must vanish in the same cycle.
        do_reset(0);
        cur_op = OP_SW; cur_funct = '0;
        repeat (3) cycle(1'b1, 1'b0);
        mem_rdy = 1'b1;
        #2;
        check_int("memwr_before_rst", int'(act.mem_write), 1);
        rst0 = 1'b1;
        #1;
        check_out("memwr_abort", act, '0);
        model_reset(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        run_instr(OP_R, F_ADDU, 1'b0, 0, 0, 1'b0, lat, rw, mw, pcw);
        check_int("after_abort_lat", lat, 4);
        check_int("after_abort_regwrite", rw, 1);

        // Illegal opcode traps and stays trapped with no strobes.
        run_instr(OP_BAD, 6'd0, 1'b0, 0, 0, 1'b0, lat, rw, mw, pcw);
        check_int("trap_entry_lat", lat, 3);
        trapc = 0;
        repeat (20) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            trapc += int'(last.trap);
            rw += int'(last.reg_write); mw += int'(last.mem_write); pcw += int'(last.pcwr);
        end
        check_int("trap_held", trapc, 20);
        check_int("trap_strobes", rw + mw + pcw, 0);

        // Randomized instruction streams on both builds.
        pool = '{OP_R, OP_ORI, OP_LUI, OP_ADDIU, OP_LW, OP_LB, OP_LH, OP_SW, OP_SB, OP_SH,
                 OP_BEQ, OP_J, OP_JAL, OP_BAD};
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            for (int k = 0; k < 120; k++) begin
                logic [5:0] op, fn;
                int idx;
                idx = $urandom_range(0, 13);
                op  = (idx == 13) ? 6'($urandom) : pool[idx];
                fn  = ($urandom_range(0, 4) == 0) ? F_JR : 6'($urandom);
                run_instr(op, fn, 1'($urandom_range(0, 1)), 0, 0, 1'b1, lat, rw, mw, pcw);
                if (last.state == ST_TRAP || plan_q[0] == ST_TRAP) do_reset(d);
            end
        end

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
